// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: shadows in-flight destinations and their
// T_new countdowns, and produces stall, per-port forwarding selects and MD busy.
module hazard_scoreboard #(
    parameter  int NUM_READ    = 2,
    parameter  int DEPTH       = 3,
    parameter  int TW          = 3,
    parameter  int MULT_CYCLES = 5,
    parameter  int DIV_CYCLES  = 10,
    localparam int W           = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic [NUM_READ*5-1:0]  id_rs_addr,
    input  logic [NUM_READ*TW-1:0] id_tuse,
    input  logic [4:0]             id_wr_addr,
    input  logic [TW-1:0]          id_tnew,
    input  logic                   id_md_start,
    input  logic                   id_md_is_div,
    input  logic                   id_md_use,
    output logic                   stall,
    output logic [NUM_READ*W-1:0]  fwd_sel,
    output logic                   md_busy
);

    localparam int MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int MDW    = $clog2(MD_MAX + 1);

    logic [4:0]    r_slot_wr   [DEPTH];
    logic [TW-1:0] r_slot_tnew [DEPTH];
    logic [MDW-1:0] r_md_cnt;

    logic [NUM_READ-1:0] w_port_stall;
    logic                w_md_stall;
    logic                w_accept;

    // Slot 0 takes the accepted instruction or a bubble; the pipe never freezes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slot_wr[0]   <= '0;
            r_slot_tnew[0] <= '0;
        end else begin
            r_slot_wr[0]   <= w_accept ? id_wr_addr : 5'd0;
            r_slot_tnew[0] <= w_accept ? id_tnew : '0;
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi < DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_slot_wr[gi]   <= '0;
                    r_slot_tnew[gi] <= '0;
                end else begin
                    r_slot_wr[gi]   <= r_slot_wr[gi-1];
                    r_slot_tnew[gi] <= (r_slot_tnew[gi-1] == '0) ? '0
                                                                  : r_slot_tnew[gi-1] - 1'b1;
                end
            end
        end

        for (gi = 0; gi < NUM_READ; gi++) begin : g_port
            logic [4:0]    w_rs;
            logic [TW-1:0] w_tuse;
            logic          w_hit;
            logic [W-1:0]  w_idx;
            logic [TW-1:0] w_tn;

            assign w_rs   = id_rs_addr[gi*5 +: 5];
            assign w_tuse = id_tuse[gi*TW +: TW];

            // Scan oldest to youngest so the youngest match overwrites older ones.
            always_comb begin
                w_hit = 1'b0;
                w_idx = '0;
                w_tn  = '0;
                for (int k = DEPTH - 1; k >= 0; k--) begin
                    if (w_rs != 5'd0 && r_slot_wr[k] == w_rs) begin
                        w_hit = 1'b1;
                        w_idx = W'(k);
                        w_tn  = r_slot_tnew[k];
                    end
                end
            end

            assign w_port_stall[gi]     = w_hit && (w_tn > w_tuse);
            assign fwd_sel[gi*W +: W]   = (w_hit && w_tn == '0) ? w_idx + W'(1) : '0;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_md_cnt <= '0;
        end else if (w_accept && id_md_start) begin
            r_md_cnt <= id_md_is_div ? MDW'(DIV_CYCLES) : MDW'(MULT_CYCLES);
        end else if (r_md_cnt != '0) begin
            r_md_cnt <= r_md_cnt - 1'b1;
        end
    end

    assign md_busy    = (r_md_cnt != '0);
    assign w_md_stall = id_valid && id_md_use && md_busy;
    assign stall      = id_valid && ((|w_port_stall) || w_md_stall);
    assign w_accept   = id_valid && !stall;

endmodule
